// File: rtl/csel_pkg.sv
// csel_pkg: shared defaults and result-flag layout for the carry-select adder pipeline
package csel_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;
  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_W = 2;
endpackage

// File: rtl/csel_block.sv
// csel_block: one carry-select group, precomputing sum/carry for both possible carry-ins
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout0,
  output logic             cout1,
  output logic             ctop0,
  output logic             ctop1
);
  always_comb begin
    {cout0, sum0} = {1'b0, a} + {1'b0, b};
    {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
    // carry into the top bit is recovered from that bit's sum and operands
    ctop0 = sum0[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];
    ctop1 = sum1[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];
  end
endmodule

// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: two-stage carry-select add/subtract with valid/ready flow control
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_BLOCKS = WIDTH / BLOCK;
  if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK");
  end
  logic [WIDTH-1:0] yb;
  logic ci;
  logic [NUM_BLOCKS-1:0][BLOCK-1:0] s0, s1, r_s0, r_s1;
  logic [NUM_BLOCKS-1:0] c0, c1, r_c0, r_c1;
  logic ct0, ct1, r_ct0, r_ct1, r_cin, r_v, adv;
  logic [NUM_BLOCKS:0] c;
  logic [WIDTH-1:0] sum_n;
  logic [FLAG_W-1:0] flags, flags_n;
  assign yb = y ^ {WIDTH{sub}};
  assign ci = sub | cin;
  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    if (i == NUM_BLOCKS - 1) begin : g_msb
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a(x[i*BLOCK +: BLOCK]), .b(yb[i*BLOCK +: BLOCK]),
        .sum0(s0[i]), .sum1(s1[i]), .cout0(c0[i]), .cout1(c1[i]),
        .ctop0(ct0), .ctop1(ct1)
      );
    end else begin : g_low
      logic unused_ct0, unused_ct1;
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a(x[i*BLOCK +: BLOCK]), .b(yb[i*BLOCK +: BLOCK]),
        .sum0(s0[i]), .sum1(s1[i]), .cout0(c0[i]), .cout1(c1[i]),
        .ctop0(unused_ct0), .ctop1(unused_ct1)
      );
    end
  end
  assign adv = r_v && (!out_valid || out_ready);
  assign in_ready = !r_v || adv;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= 1'b0;
    end else if (in_ready) begin
      r_v <= in_valid;
      if (in_valid) begin
        r_s0 <= s0;
        r_s1 <= s1;
        r_c0 <= c0;
        r_c1 <= c1;
        r_ct0 <= ct0;
        r_ct1 <= ct1;
        r_cin <= ci;
      end
    end
  end
  always_comb begin
    c = '0;
    sum_n = '0;
    flags_n = '0;
    c[0] = r_cin;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      sum_n[i*BLOCK +: BLOCK] = c[i] ? r_s1[i] : r_s0[i];
      c[i+1] = c[i] ? r_c1[i] : r_c0[i];
    end
    flags_n[FLAG_COUT] = c[NUM_BLOCKS];
    flags_n[FLAG_OVF] = c[NUM_BLOCKS] ^ (c[NUM_BLOCKS-1] ? r_ct1 : r_ct0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum <= '0;
      flags <= '0;
    end else begin
      if (!out_valid || out_ready) out_valid <= r_v;
      if (adv) begin
        sum <= sum_n;
        flags <= flags_n;
      end
    end
  end
  assign cout = flags[FLAG_COUT];
  assign ovf = flags[FLAG_OVF];
endmodule

// File: doc/csel_adder_pipe.md
CSEL_ADDER_PIPE -- requirements
Module: csel_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 4, carry-select group width in bits.
REQ-003 SHALL have clock input clk (1): the only clock; all state updates on its rising edge.
REQ-004 SHALL have reset input rst (1): reset is synchronous and active-high.
REQ-005 SHALL have input in_valid (1): the operand set is valid this cycle.
REQ-006 SHALL have output in_ready (1): the block accepts an operand set this cycle.
REQ-007 SHALL have input x (WIDTH): operand A.
REQ-008 SHALL have input y (WIDTH): operand B.
REQ-009 SHALL have input cin (1): carry-in; ignored when sub=1.
REQ-010 SHALL have input sub (1): 0 gives x+y+cin; 1 gives x-y.
REQ-011 SHALL have output out_valid (1): the result is valid.
REQ-012 SHALL have input out_ready (1): downstream accepts the result.
REQ-013 SHALL have output sum (WIDTH): result modulo 2^WIDTH.
REQ-014 SHALL have output cout (1): carry-out; for sub=1 it means no borrow (x>=y unsigned).
REQ-015 SHALL have output ovf (1): two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

Function
REQ-016 SHALL accept an operand set on a cycle where in_valid && in_ready.
REQ-017 SHALL form the effective B as y XOR {WIDTH{sub}}, and the effective carry-in as cin when sub=0, or 1 when sub=1.
REQ-018 Stage 1 SHALL split the operands into NUM_BLOCKS = WIDTH/BLOCK groups.
REQ-019 Stage 1 SHALL compute, for each group, the sum and carry-out for both assumed carry-in 0 and 1, and register them with the resolved carry-in of group 0 and a stage-1 valid bit.
REQ-020 Stage 2 SHALL resolve the carry chain by muxing each group's precomputed pair on the previous group's selected carry-out, and register sum, cout, ovf and out_valid.
REQ-021 Latency SHALL be 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-022 Throughput SHALL be one operation per cycle under continuous out_ready=1.
REQ-023 Stage 2 SHALL hold sum, cout, ovf and out_valid stable while out_valid && !out_ready.
REQ-024 Stage 1 SHALL advance into stage 2 only when stage 2 is empty or is draining on the same cycle (out_ready=1).
REQ-025 in_ready SHALL equal !s1_valid || s1 advancing; it may depend combinationally on out_ready.
REQ-026 Under sustained out_ready=0, at most 2 operations SHALL be held in flight, and in_ready SHALL then be 0.
REQ-027 Results SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-028 When accept and drain occur on the same cycle with both stages full, all stages SHALL shift without a bubble.
REQ-029 sum, cout and ovf SHALL be don't-care while out_valid=0, but SHALL be driven, never X, after reset.
REQ-030 WIDTH not a multiple of BLOCK, or BLOCK>WIDTH, SHALL be rejected at elaboration.
REQ-031 WIDTH==BLOCK SHALL be legal, giving a single group with no select mux.

Reset
REQ-032 rst=1 at a clock edge SHALL clear the s1 valid bit and out_valid to 0, and clear sum, cout and ovf to 0.
REQ-033 in_ready SHALL be 1 in the cycle after reset is released.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations, with no out_valid pulse afterwards for those operations.
REQ-035 An input presented while rst=1 SHALL NOT be accepted.

Structure
REQ-036 Shared package csel_pkg SHALL hold DEF_WIDTH=16, DEF_BLOCK=4 and the result-flag field layout constants.
REQ-037 NUM_BLOCKS SHALL be a localparam derived in-module.
REQ-038 One sub-module, csel_block, SHALL be instantiated NUM_BLOCKS times.
REQ-039 csel_block SHALL be combinational, taking BLOCK-bit a, b and returning sum0/cout0 and sum1/cout1 from two ripple adders.
REQ-040 The MSB group's csel_block SHALL also export the carry into its top bit, for ovf.

Verification (WIDTH=16, BLOCK=4 unless noted)
REQ-041 x=0x0001, y=0x0008, cin=1, sub=0 -> after 2 cycles sum=0x000A, cout=0, ovf=0.
REQ-042 x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; x=0x7FFF, y=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-043 sub=1, x=0x0005, y=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; x=0x8000, y=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-044 Backpressure: out_ready=0 while offering 3 back-to-back operations -> exactly 2 accepted, in_ready=0 from the 3rd cycle, outputs held; raise out_ready -> results in order, one per cycle, 3rd accepted the same cycle the 1st drains.
REQ-045 Reset mid-stream: accept 2 operations, then assert rst for 1 cycle -> out_valid=0 and sum=0 the next cycle, no stale results afterwards, in_ready=1.
REQ-046 Random self-check, 10k operations with random out_ready, at (16,4), (4,4) and (32,8) -> every result equals the reference x±y model, including cout and ovf.
